// File: rtl/riscv_pkg.sv
// Shared opcodes, FSM state encoding, mux select codes and ALU operation codes
// for the multicycle RISC-V control path.
package riscv_pkg;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_B   = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_LUI = 7'b0110111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_LUI      = 4'd11,
      S_TRAP     = 4'd12
   } state_t;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLT  = 4'd5;
   localparam logic [3:0] ALU_SLTU = 4'd6;
   localparam logic [3:0] ALU_SLL  = 4'd7;
   localparam logic [3:0] ALU_SRL  = 4'd8;
   localparam logic [3:0] ALU_SRA  = 4'd9;

   // Moore control word produced by the main FSM
   typedef struct packed {
      logic       pcwrite;
      logic       adrsrc;
      logic       irwrite;
      logic       memwrite;
      logic       regwrite;
      logic       branch;
      logic       illegal;
      logic [1:0] resultsrc;
      logic [1:0] alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
   } ctrl_t;

   function automatic logic [2:0] immsrc_of(input logic [6:0] op);
      case (op)
         OP_SW:   return IMM_S;
         OP_B:    return IMM_B;
         OP_JAL:  return IMM_J;
         OP_LUI:  return IMM_U;
         default: return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/aludec.sv
// ALU operation decode from ALUOp/funct3/funct7b5; purely combinational.
// Shift encodings only exist when the control bus is wide enough to carry them.
module aludec
   import riscv_pkg::*;
#(
   parameter int W = 3
) (
   input  logic         op5,
   input  logic [2:0]   funct3,
   input  logic         funct7b5,
   input  logic [1:0]   aluop,
   output logic [W-1:0] alucontrol
);

   logic [3:0] code;

   always_comb begin
      code = ALU_ADD;
      case (aluop)
         ALUOP_SUB: code = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               3'b000:  code = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
               3'b010:  code = ALU_SLT;
               3'b011:  code = ALU_SLTU;
               3'b100:  code = ALU_XOR;
               3'b110:  code = ALU_OR;
               3'b111:  code = ALU_AND;
               3'b001:  code = (W >= 4) ? ALU_SLL : ALU_ADD;
               default: code = (W >= 4) ? (funct7b5 ? ALU_SRA : ALU_SRL) : ALU_ADD;
            endcase
         end
         default: code = ALU_ADD;
      endcase
   end

   assign alucontrol = W'(code);

endmodule

// File: rtl/mc_mainfsm.sv
// Multicycle main FSM: state register, next-state logic and Moore control word.
// Fetch/memread/memwrite hold until mem_ready; TRAP is left only through reset.
module mc_mainfsm
   import riscv_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic       mem_ready,
   output state_t     state,
   output ctrl_t      ctrl
);

   state_t nxt;

   always_ff @(posedge clk) begin
      if (reset) state <= S_FETCH;
      else       state <= nxt;
   end

   always_comb begin
      nxt  = state;
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.alusrca   = SRCA_PC;
            ctrl.alusrcb   = SRCB_FOUR;
            ctrl.aluop     = ALUOP_ADD;
            ctrl.resultsrc = RES_ALURESULT;
            ctrl.irwrite   = mem_ready;
            ctrl.pcwrite   = mem_ready;
            if (mem_ready) nxt = S_DECODE;
         end
         S_DECODE: begin
            // branch/jump target is precomputed into ALUOut here
            ctrl.alusrca = SRCA_OLDPC;
            ctrl.alusrcb = SRCB_IMM;
            case (op)
               OP_LW, OP_SW: nxt = S_MEMADR;
               OP_R:         nxt = S_EXECR;
               OP_I:         nxt = S_EXECI;
               OP_B:         nxt = S_BRANCH;
               OP_JAL:       nxt = S_JAL;
               OP_LUI:       nxt = S_LUI;
               default:      nxt = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            ctrl.alusrca = SRCA_RS1;
            ctrl.alusrcb = SRCB_IMM;
            nxt = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            ctrl.adrsrc = 1'b1;
            if (mem_ready) nxt = S_MEMWB;
         end
         S_MEMWB: begin
            ctrl.resultsrc = RES_DATA;
            ctrl.regwrite  = 1'b1;
            nxt = S_FETCH;
         end
         S_MEMWRITE: begin
            ctrl.adrsrc   = 1'b1;
            ctrl.memwrite = 1'b1;
            if (mem_ready) nxt = S_FETCH;
         end
         S_EXECR: begin
            ctrl.alusrca = SRCA_RS1;
            ctrl.alusrcb = SRCB_RS2;
            ctrl.aluop   = ALUOP_FUNCT;
            nxt = S_ALUWB;
         end
         S_EXECI: begin
            ctrl.alusrca = SRCA_RS1;
            ctrl.alusrcb = SRCB_IMM;
            ctrl.aluop   = ALUOP_FUNCT;
            nxt = S_ALUWB;
         end
         S_ALUWB: begin
            ctrl.resultsrc = RES_ALUOUT;
            ctrl.regwrite  = 1'b1;
            nxt = S_FETCH;
         end
         S_BRANCH: begin
            ctrl.alusrca   = SRCA_RS1;
            ctrl.alusrcb   = SRCB_RS2;
            ctrl.aluop     = ALUOP_SUB;
            ctrl.resultsrc = RES_ALUOUT;
            ctrl.branch    = 1'b1;
            nxt = S_FETCH;
         end
         S_JAL: begin
            // ALU forms OldPC+4 for the link write in ALUWB
            ctrl.alusrca   = SRCA_OLDPC;
            ctrl.alusrcb   = SRCB_FOUR;
            ctrl.resultsrc = RES_ALUOUT;
            ctrl.pcwrite   = 1'b1;
            nxt = S_ALUWB;
         end
         S_LUI: begin
            ctrl.alusrca = SRCA_ZERO;
            ctrl.alusrcb = SRCB_IMM;
            nxt = S_ALUWB;
         end
         S_TRAP: begin
            ctrl.illegal = 1'b1;
            nxt = S_TRAP;
         end
         default: nxt = S_FETCH;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V control unit: Moore FSM plus ALU decode and branch resolution.
// Memory states stall on MemReady; outputs hold steady across the stall.
module mc_controller
   import riscv_pkg::*;
#(
   parameter int ALU_CTRL_W    = 3,
   parameter bit HAS_MEM_READY = 1'b1,
   parameter bit BRANCH_FULL   = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [6:0]            op,
   input  logic [2:0]            funct3,
   input  logic                  funct7b5,
   input  logic                  Zero,
   input  logic                  LtS,
   input  logic                  LtU,
   input  logic                  MemReady,
   output logic                  PCWrite,
   output logic                  AdrSrc,
   output logic                  IRWrite,
   output logic                  MemWrite,
   output logic                  RegWrite,
   output logic [1:0]            ResultSrc,
   output logic [1:0]            ALUSrcA,
   output logic [1:0]            ALUSrcB,
   output logic [2:0]            ImmSrc,
   output logic [ALU_CTRL_W-1:0] ALUControl,
   output logic                  Illegal,
   output logic [3:0]            State
);

   state_t fsm_state;
   ctrl_t  ctrl;
   logic   mem_rdy;
   logic   taken;

   assign mem_rdy = HAS_MEM_READY ? MemReady : 1'b1;

   mc_mainfsm u_fsm (
      .clk       (clk),
      .reset     (reset),
      .op        (op),
      .mem_ready (mem_rdy),
      .state     (fsm_state),
      .ctrl      (ctrl)
   );

   aludec #(.W(ALU_CTRL_W)) u_aludec (
      .op5        (op[5]),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .aluop      (ctrl.aluop),
      .alucontrol (ALUControl)
   );

   // funct3 010/011 are reserved encodings and never branch
   always_comb begin
      taken = 1'b0;
      if (BRANCH_FULL) begin
         case (funct3)
            3'b000:  taken = Zero;
            3'b001:  taken = ~Zero;
            3'b100:  taken = LtS;
            3'b101:  taken = ~LtS;
            3'b110:  taken = LtU;
            3'b111:  taken = ~LtU;
            default: taken = 1'b0;
         endcase
      end else begin
         taken = (funct3 == 3'b000) & Zero;
      end
   end

   assign PCWrite   = ctrl.pcwrite | (ctrl.branch & taken);
   assign AdrSrc    = ctrl.adrsrc;
   assign IRWrite   = ctrl.irwrite;
   assign MemWrite  = ctrl.memwrite;
   assign RegWrite  = ctrl.regwrite;
   assign ResultSrc = ctrl.resultsrc;
   assign ALUSrcA   = ctrl.alusrca;
   assign ALUSrcB   = ctrl.alusrcb;
   assign ImmSrc    = immsrc_of(op);
   assign Illegal   = ctrl.illegal;
   assign State     = fsm_state;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed table, hand-written corner sequences and a
// randomized run against an instruction-path reference model.
module tb_mc_controller;
   import riscv_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5, Zero, LtS, LtU, MemReady;

   logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, Illegal;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
   logic [2:0] ImmSrc, ALUControl;
   logic [3:0] State;

   logic       b_PCWrite, b_AdrSrc, b_IRWrite, b_MemWrite, b_RegWrite, b_Illegal;
   logic [1:0] b_ResultSrc, b_ALUSrcA, b_ALUSrcB;
   logic [2:0] b_ImmSrc, b_ALUControl;
   logic [3:0] b_State;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mc_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(Zero), .LtS(LtS), .LtU(LtU), .MemReady(MemReady),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
      .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Illegal(Illegal), .State(State)
   );

   mc_controller #(.BRANCH_FULL(1'b0)) dut_b0 (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(Zero), .LtS(LtS), .LtU(LtU), .MemReady(MemReady),
      .PCWrite(b_PCWrite), .AdrSrc(b_AdrSrc), .IRWrite(b_IRWrite), .MemWrite(b_MemWrite),
      .RegWrite(b_RegWrite), .ResultSrc(b_ResultSrc), .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB),
      .ImmSrc(b_ImmSrc), .ALUControl(b_ALUControl), .Illegal(b_Illegal), .State(b_State)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   function automatic logic [12:0] main_vec();
      return {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, Illegal};
   endfunction

   function automatic logic [12:0] b0_vec();
      return {b_PCWrite, b_AdrSrc, b_IRWrite, b_MemWrite, b_RegWrite, b_ResultSrc,
              b_ALUSrcA, b_ALUSrcB, b_Illegal};
   endfunction

   // Expected control outputs for a state, as the state table describes them.
   // Field order: pcw adr irw memw regw rs[2] a[2] b[2] ill
   function automatic logic [12:0] exp_ctl(input int st, input logic mr, input logic tk);
      case (st)
         0:  return {mr, 1'b0, mr, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
         1:  return {5'b00000, 2'b00, 2'b01, 2'b01, 1'b0};
         2:  return {5'b00000, 2'b00, 2'b10, 2'b01, 1'b0};
         3:  return {5'b01000, 2'b00, 2'b00, 2'b00, 1'b0};
         4:  return {5'b00001, 2'b01, 2'b00, 2'b00, 1'b0};
         5:  return {5'b01010, 2'b00, 2'b00, 2'b00, 1'b0};
         6:  return {5'b00000, 2'b00, 2'b10, 2'b00, 1'b0};
         7:  return {5'b00000, 2'b00, 2'b10, 2'b01, 1'b0};
         8:  return {5'b00001, 2'b00, 2'b00, 2'b00, 1'b0};
         9:  return {tk, 4'b0000, 2'b00, 2'b10, 2'b00, 1'b0};
         10: return {5'b10000, 2'b00, 2'b01, 2'b10, 1'b0};
         11: return {5'b00000, 2'b00, 2'b11, 2'b01, 1'b0};
         default: return {12'b0, 1'b1};
      endcase
   endfunction

   function automatic logic br_taken(input logic [2:0] f3, input logic z, input logic lts,
                                     input logic ltu, input logic full);
      if (!full) return (f3 == 3'b000) && z;
      case (f3)
         3'b000:  return z;
         3'b001:  return !z;
         3'b100:  return lts;
         3'b101:  return !lts;
         3'b110:  return ltu;
         3'b111:  return !ltu;
         default: return 1'b0;
      endcase
   endfunction

   // add everywhere, sub while comparing in BRANCH, the instruction's own op in EXEC
   function automatic logic [2:0] exp_alu(input int st, input logic [6:0] o,
                                          input logic [2:0] f3, input logic f7);
      if (st == 9) return 3'd1;
      if (st != 6 && st != 7) return 3'd0;
      case (f3)
         3'b000:  return (o == OP_R && f7) ? 3'd1 : 3'd0;
         3'b010:  return 3'd5;
         3'b011:  return 3'd6;
         3'b100:  return 3'd4;
         3'b110:  return 3'd3;
         3'b111:  return 3'd2;
         default: return 3'd0;
      endcase
   endfunction

   function automatic logic [2:0] exp_imm(input logic [6:0] o);
      if (o == OP_SW)  return 3'd1;
      if (o == OP_B)   return 3'd2;
      if (o == OP_JAL) return 3'd3;
      if (o == OP_LUI) return 3'd4;
      return 3'd0;
   endfunction

   typedef struct {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        f7, z, lts, ltu;
      int          cpi;
      logic [31:0] path;
      int          pcw, pcw_b0, regw, memw;
      logic [2:0]  alu2;
   } vec_t;

   vec_t vt[15];

   initial begin
      int q[$];
      int idx, st, waits, cyc;
      int pcw, pcwb, regw, memw;
      int lwst[8];
      logic lwmr[8];
      logic [12:0] hold;
      logic tk;

      reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
      Zero = 1'b0; LtS = 1'b0; LtU = 1'b0; MemReady = 1'b0;

      vt[0]  = '{OP_R,   3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 32'h0000_8610, 1, 1, 1, 0, 3'd0};
      vt[1]  = '{OP_R,   3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4, 32'h0000_8610, 1, 1, 1, 0, 3'd1};
      vt[2]  = '{OP_I,   3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4, 32'h0000_8710, 1, 1, 1, 0, 3'd0};
      vt[3]  = '{OP_I,   3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4, 32'h0000_8710, 1, 1, 1, 0, 3'd5};
      vt[4]  = '{OP_LW,  3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5, 32'h0004_3210, 1, 1, 1, 0, 3'd0};
      vt[5]  = '{OP_SW,  3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4, 32'h0000_5210, 1, 1, 0, 1, 3'd0};
      vt[6]  = '{OP_B,   3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3, 32'h0000_0910, 2, 2, 0, 0, 3'd1};
      vt[7]  = '{OP_B,   3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3, 32'h0000_0910, 2, 1, 0, 0, 3'd1};
      vt[8]  = '{OP_B,   3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 3, 32'h0000_0910, 1, 1, 0, 0, 3'd1};
      vt[9]  = '{OP_B,   3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 3, 32'h0000_0910, 2, 1, 0, 0, 3'd1};
      vt[10] = '{OP_B,   3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 3, 32'h0000_0910, 1, 1, 0, 0, 3'd1};
      vt[11] = '{OP_B,   3'd6, 1'b0, 1'b0, 1'b0, 1'b1, 3, 32'h0000_0910, 2, 1, 0, 0, 3'd1};
      vt[12] = '{OP_B,   3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 3, 32'h0000_0910, 1, 1, 0, 0, 3'd1};
      vt[13] = '{OP_JAL, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 32'h0000_8A10, 2, 2, 1, 0, 3'd0};
      vt[14] = '{OP_LUI, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 32'h0000_8B10, 1, 1, 1, 0, 3'd0};

      // reset state
      tick(); tick();
      #2;
      chk("reset_state", 32'(State), 32'd0);
      chk("reset_enables", 32'({PCWrite, IRWrite, MemWrite, RegWrite}), 32'd0);
      chk("reset_ctl", 32'(main_vec()), 32'(exp_ctl(0, 1'b0, 1'b0)));
      reset = 1'b0;
      tick();

      // directed table, MemReady held high
      foreach (vt[i]) begin
         op = vt[i].op; funct3 = vt[i].f3; funct7b5 = vt[i].f7;
         Zero = vt[i].z; LtS = vt[i].lts; LtU = vt[i].ltu; MemReady = 1'b1;
         pcw = 0; pcwb = 0; regw = 0; memw = 0;
         for (int c = 0; c < vt[i].cpi; c++) begin
            #2;
            chk($sformatf("vec%0d_state_c%0d", i, c), 32'(State), 32'(vt[i].path[c*4 +: 4]));
            if (c == 2) chk($sformatf("vec%0d_aluctl", i), 32'(ALUControl), 32'(vt[i].alu2));
            pcw += int'(PCWrite); pcwb += int'(b_PCWrite);
            regw += int'(RegWrite); memw += int'(MemWrite);
            tick();
         end
         #2;
         chk($sformatf("vec%0d_back_to_fetch", i), 32'(State), 32'd0);
         chk($sformatf("vec%0d_pcwrite_cycles", i), 32'(pcw), 32'(vt[i].pcw));
         chk($sformatf("vec%0d_pcwrite_b0_cycles", i), 32'(pcwb), 32'(vt[i].pcw_b0));
         chk($sformatf("vec%0d_regwrite_cycles", i), 32'(regw), 32'(vt[i].regw));
         chk($sformatf("vec%0d_memwrite_cycles", i), 32'(memw), 32'(vt[i].memw));
         tick();
         do_reset();
      end

      // reset asserted in the middle of a load
      op = OP_LW; funct3 = 3'd2; MemReady = 1'b1;
      tick(); tick(); tick();
      MemReady = 1'b0;
      #2;
      chk("midrst_in_memread", 32'(State), 32'd3);
      reset = 1'b1;
      tick();
      #2;
      chk("midrst_state", 32'(State), 32'd0);
      chk("midrst_enables", 32'({PCWrite, IRWrite, MemWrite, RegWrite}), 32'd0);
      reset = 1'b0; MemReady = 1'b1;
      #1;
      chk("midrst_release_irwrite", 32'(IRWrite), 32'd1);
      tick();
      do_reset();

      // load with two MemReady-low cycles in MEMREAD
      lwst = '{0, 1, 2, 3, 3, 3, 4, 0};
      lwmr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      hold = exp_ctl(3, 1'b0, 1'b0);
      op = OP_LW;
      for (int c = 0; c < 8; c++) begin
         MemReady = lwmr[c];
         #2;
         chk($sformatf("lwwait_state_c%0d", c), 32'(State), 32'(lwst[c]));
         if (lwst[c] == 3) chk($sformatf("lwwait_hold_c%0d", c), 32'(main_vec()), 32'(hold));
         tick();
      end
      do_reset();

      // illegal opcode: trap held until reset
      op = 7'b1111111; MemReady = 1'b1;
      tick();
      #2;
      chk("trap_decode", 32'(State), 32'd1);
      tick();
      for (int c = 0; c < 10; c++) begin
         MemReady = c[0];
         #2;
         chk($sformatf("trap_hold_c%0d", c), 32'({State, Illegal, PCWrite, IRWrite, MemWrite, RegWrite}),
             32'({4'd12, 5'b10000}));
         tick();
      end
      do_reset();
      #2;
      chk("trap_exit_by_reset", 32'({State, Illegal}), 32'd0);
      tick();
      do_reset();

      // randomized instruction stream against the path model
      for (int n = 0; n < 80; n++) begin
         case ($urandom_range(0, 7))
            0: op = OP_LW;  1: op = OP_SW;  2: op = OP_R;   3: op = OP_I;
            4: op = OP_B;   5: op = OP_JAL; 6: op = OP_LUI;
            default: begin
               op = 7'($urandom);
               if (op == OP_LW || op == OP_SW || op == OP_R || op == OP_I ||
                   op == OP_B || op == OP_JAL || op == OP_LUI) op = 7'h00;
            end
         endcase
         funct3 = 3'($urandom); funct7b5 = 1'($urandom);
         q.delete();
         if (op == OP_LW)       q = '{0, 1, 2, 3, 4};
         else if (op == OP_SW)  q = '{0, 1, 2, 5};
         else if (op == OP_R)   q = '{0, 1, 6, 8};
         else if (op == OP_I)   q = '{0, 1, 7, 8};
         else if (op == OP_B)   q = '{0, 1, 9};
         else if (op == OP_JAL) q = '{0, 1, 10, 8};
         else if (op == OP_LUI) q = '{0, 1, 11, 8};
         else                   q = '{0, 1, 12};
         idx = 0; waits = 0; cyc = 0;
         while (idx < q.size()) begin
            st = q[idx];
            Zero = 1'($urandom); LtS = 1'($urandom); LtU = 1'($urandom);
            MemReady = (waits >= 6) ? 1'b1 : ($urandom_range(0, 3) != 0);
            #2;
            tk = br_taken(funct3, Zero, LtS, LtU, 1'b1);
            chk($sformatf("rnd%0d_state", n), 32'(State), 32'(st));
            chk($sformatf("rnd%0d_ctl_st%0d", n, st), 32'(main_vec()), 32'(exp_ctl(st, MemReady, tk)));
            chk($sformatf("rnd%0d_b0_ctl_st%0d", n, st), 32'(b0_vec()),
                32'(exp_ctl(st, MemReady, br_taken(funct3, Zero, LtS, LtU, 1'b0))));
            chk($sformatf("rnd%0d_alu_st%0d", n, st), 32'(ALUControl), 32'(exp_alu(st, op, funct3, funct7b5)));
            chk($sformatf("rnd%0d_imm", n), 32'(ImmSrc), 32'(exp_imm(op)));
            cyc++;
            if (st == 12) begin
               if (cyc >= 5) begin
                  do_reset();
                  break;
               end
            end else if ((st == 0 || st == 3 || st == 5) && !MemReady) begin
               waits++;
            end else begin
               idx++;
               waits = 0;
            end
            tick();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle RISC-V control unit: the next generation of the single-cycle `controller`. It replaces the combinational decoder with a Moore state machine that sequences fetch, decode, execute, memory and writeback over several cycles on a shared ALU and a unified memory. It waits on a memory-ready handshake. It resolves the full RV32I conditional-branch set, `jal` and `lui`. It traps illegal opcodes. It sits between the instruction register and the multicycle datapath.

## Interface
- `ALU_CTRL_W`, default 3: ALUControl width, minimum 3. Codes are zero-extended.
- `HAS_MEM_READY`, default 1: when 0, `MemReady` is ignored and treated as 1.
- `BRANCH_FULL`, default 1: when 1, decode beq/bne/blt/bge/bltu/bgeu. When 0, only beq is decoded; any other funct3 is not-taken.
- `clk` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `op` in 7: opcode from the instruction register.
- `funct3` in 3: from the instruction register.
- `funct7b5` in 1: instruction bit 30.
- `Zero` in 1: ALU result equals zero.
- `LtS` in 1: ALU signed less-than.
- `LtU` in 1: ALU unsigned less-than.
- `MemReady` in 1: memory completes the current access this cycle.
- `PCWrite` out 1: PC register enable.
- `AdrSrc` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `IRWrite` out 1: IR and OldPC enable.
- `MemWrite` out 1: memory write strobe.
- `RegWrite` out 1: register file write enable.
- `ResultSrc` out 2: 00 ALUOut, 01 Data, 10 ALUResult.
- `ALUSrcA` out 2: 00 PC, 01 OldPC, 10 rs1, 11 zero.
- `ALUSrcB` out 2: 00 rs2, 01 Imm, 10 constant 4.
- `ImmSrc` out 3: 000 I, 001 S, 010 B, 011 J, 100 U.
- `ALUControl` out ALU_CTRL_W: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu.
- `Illegal` out 1: high while in TRAP.
- `State` out 4: current state, for debug.

## Operation
- Reset state is FETCH. `reset` has priority over every transition, including a mid-instruction reset.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, LUI 11, TRAP 12.
- Outputs not listed for a state are 0.
- **FETCH**: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCWrite = MemReady. Stay in FETCH until MemReady, then go to DECODE.
- **DECODE**: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jump target into ALUOut). Next state by `op`:
  - lw/sw → MEMADR
  - R → EXECR
  - I-ALU → EXECI
  - branch → BRANCH
  - jal → JAL
  - lui → LUI
  - anything else → TRAP
- **MEMADR**: ALUSrcA=10, ALUSrcB=01, ALUOp=00. lw → MEMREAD, sw → MEMWRITE.
- **MEMREAD**: AdrSrc=1. Hold until MemReady, then go to MEMWB.
- **MEMWB**: ResultSrc=01, RegWrite=1. Then FETCH.
- **MEMWRITE**: AdrSrc=1, MemWrite=1. Hold, with MemWrite held high, until MemReady, then FETCH.
- **EXECR**: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Then ALUWB.
- **EXECI**: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Then ALUWB.
- **ALUWB**: ResultSrc=00, RegWrite=1. Then FETCH.
- **BRANCH**: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00. PCWrite = taken. Then FETCH.
  - taken by funct3: 000 Zero, 001 !Zero, 100 LtS, 101 !LtS, 110 LtU, 111 !LtU.
  - funct3 010 and 011 are not-taken.
- **JAL**: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1. Then ALUWB, which writes PC+4 to rd.
- **LUI**: ALUSrcA=11, ALUSrcB=01, ALUOp=00. Then ALUWB.
- **TRAP**: Illegal=1, all enables 0. Exited only by reset.
- **ALU decode**, from ALUOp:
  - ALUOp 00 → add; 01 → sub.
  - ALUOp 10 decodes funct3 as in the single-cycle design:
    - funct3 000: sub iff funct7b5 & op[5], else add.
    - 010 slt, 011 sltu, 100 xor, 110 or, 111 and.
    - 001/101 (shifts) → add when ALU_CTRL_W=3.
- **ImmSrc** is combinational from `op` in every state.

## Timing
- All outputs except ImmSrc and ALUControl are pure functions of registered state. FETCH IRWrite/PCWrite and BRANCH PCWrite also depend on the current MemReady/flags.
- CPI with MemReady tied high: R/I-ALU 4, lw 5, sw 4, branch 3, jal 4, lui 4.
- Each cycle with MemReady low in FETCH, MEMREAD or MEMWRITE adds one cycle. No output changes during the wait.
- MemReady high outside memory states is ignored.

## Structure
- `riscv_pkg` holds:
  - opcode constants: LW 0000011, SW 0100011, R 0110011, I 0010011, B 1100011, JAL 1101111, LUI 0110111;
  - the state enum;
  - ImmSrc, ResultSrc and ALUSrc codes;
  - ALU operation codes.
- One sub-module, `mc_mainfsm`: state register, next-state logic and Moore outputs.
- ALU decode reuses `aludec`; the branch-condition mux stays in the top level.

## Test plan
- Reset asserted mid-MEMREAD → next cycle State=0 and all enables 0. Release reset → FETCH with IRWrite=1.
- `add` (op 0110011, funct3 000, funct7b5 0) with MemReady=1 → states 0,1,6,8. RegWrite high only in cycle 4. ALUControl=0 in EXECR.
- `lw` with MemReady low for 2 cycles in MEMREAD → states 0,1,2,3,3,3,4,0. AdrSrc=1 throughout MEMREAD.
- `sw` with MemReady=1 → states 0,1,2,5,0. MemWrite=1 for exactly one cycle.
- `bne` (funct3 001):
  - Zero=0 → PCWrite=1 in BRANCH.
  - Zero=1 → PCWrite=0.
  - With BRANCH_FULL=0 → PCWrite=0 regardless of Zero.
- op 1111111 → DECODE then TRAP. Illegal=1 held for 10 cycles until reset.
